// File: rtl/id_ex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_reg
// ID/EX pipeline register of the 5-stage MIPS core. It captures the decoded
// operands, register indices, funct/opcode fields and main-control bits at the
// end of ID and presents them to EX one cycle later.
//
// Per-edge priority: i_reset > !i_step > i_flush > i_stall > load.
//   reset  : every output cleared
//   !step  : everything frozen; flush/stall requests are dropped, not queued
//   flush  : bubble (all-zero NOP: no write, no memory access, indices $0)
//   stall  : hold, so EX sees the same instruction again
//   load   : every o_X <= i_X
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_step                 debug enable (0 freezes the register)
//   i_stall, i_flush       hazard-unit hold / control-hazard bubble
//   i_PC .. i_Valid        ID-stage payload (data, indices, fields, control)
//   o_PC .. o_Valid        registered copy of the payload for EX
// -----------------------------------------------------------------------------
module id_ex_pipeline_reg #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned RBITS = 5,
  parameter int unsigned FBITS = 6,
  parameter int unsigned CBITS = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [NBITS-1:0] i_PC,
  input  logic [NBITS-1:0] i_RegA,
  input  logic [NBITS-1:0] i_RegB,
  input  logic [NBITS-1:0] i_Imm,
  input  logic [RBITS-1:0] i_Shamt,
  input  logic [RBITS-1:0] i_Rs,
  input  logic [RBITS-1:0] i_Rt,
  input  logic [RBITS-1:0] i_Rd,
  input  logic [FBITS-1:0] i_Funct,
  input  logic [FBITS-1:0] i_Opcode,
  input  logic [CBITS-1:0] i_ALUOp,
  input  logic             i_RegDst,
  input  logic             i_ALUSrc,
  input  logic             i_MemRead,
  input  logic             i_MemWrite,
  input  logic             i_MemToReg,
  input  logic             i_RegWrite,
  input  logic             i_Halt,
  input  logic             i_Valid,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_RegA,
  output logic [NBITS-1:0] o_RegB,
  output logic [NBITS-1:0] o_Imm,
  output logic [RBITS-1:0] o_Shamt,
  output logic [RBITS-1:0] o_Rs,
  output logic [RBITS-1:0] o_Rt,
  output logic [RBITS-1:0] o_Rd,
  output logic [FBITS-1:0] o_Funct,
  output logic [FBITS-1:0] o_Opcode,
  output logic [CBITS-1:0] o_ALUOp,
  output logic             o_RegDst,
  output logic             o_ALUSrc,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_MemToReg,
  output logic             o_RegWrite,
  output logic             o_Halt,
  output logic             o_Valid
);

  logic [NBITS-1:0] r_PC;
  logic [NBITS-1:0] r_RegA;
  logic [NBITS-1:0] r_RegB;
  logic [NBITS-1:0] r_Imm;
  logic [RBITS-1:0] r_Shamt;
  logic [RBITS-1:0] r_Rs;
  logic [RBITS-1:0] r_Rt;
  logic [RBITS-1:0] r_Rd;
  logic [FBITS-1:0] r_Funct;
  logic [FBITS-1:0] r_Opcode;
  logic [CBITS-1:0] r_ALUOp;
  logic             r_RegDst;
  logic             r_ALUSrc;
  logic             r_MemRead;
  logic             r_MemWrite;
  logic             r_MemToReg;
  logic             r_RegWrite;
  logic             r_Halt;
  logic             r_Valid;

  // Bubble and reset share the all-zero pattern: ALUOp 00 (add), no write,
  // no memory access, all indices $0 so forwarding never matches usefully.
  logic w_clear;
  logic w_load;

  assign w_clear = i_reset | (i_step & i_flush);
  assign w_load  = ~i_reset & i_step & ~i_flush & ~i_stall;

  // Pipeline register update; holding is the implicit default.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_PC       <= '0;
      r_RegA     <= '0;
      r_RegB     <= '0;
      r_Imm      <= '0;
      r_Shamt    <= '0;
      r_Rs       <= '0;
      r_Rt       <= '0;
      r_Rd       <= '0;
      r_Funct    <= '0;
      r_Opcode   <= '0;
      r_ALUOp    <= '0;
      r_RegDst   <= 1'b0;
      r_ALUSrc   <= 1'b0;
      r_MemRead  <= 1'b0;
      r_MemWrite <= 1'b0;
      r_MemToReg <= 1'b0;
      r_RegWrite <= 1'b0;
      r_Halt     <= 1'b0;
      r_Valid    <= 1'b0;
    end else if (w_load) begin
      r_PC       <= i_PC;
      r_RegA     <= i_RegA;
      r_RegB     <= i_RegB;
      r_Imm      <= i_Imm;
      r_Shamt    <= i_Shamt;
      r_Rs       <= i_Rs;
      r_Rt       <= i_Rt;
      r_Rd       <= i_Rd;
      r_Funct    <= i_Funct;
      r_Opcode   <= i_Opcode;
      r_ALUOp    <= i_ALUOp;
      r_RegDst   <= i_RegDst;
      r_ALUSrc   <= i_ALUSrc;
      r_MemRead  <= i_MemRead;
      r_MemWrite <= i_MemWrite;
      r_MemToReg <= i_MemToReg;
      r_RegWrite <= i_RegWrite;
      r_Halt     <= i_Halt;
      r_Valid    <= i_Valid;
    end
  end

  assign o_PC       = r_PC;
  assign o_RegA     = r_RegA;
  assign o_RegB     = r_RegB;
  assign o_Imm      = r_Imm;
  assign o_Shamt    = r_Shamt;
  assign o_Rs       = r_Rs;
  assign o_Rt       = r_Rt;
  assign o_Rd       = r_Rd;
  assign o_Funct    = r_Funct;
  assign o_Opcode   = r_Opcode;
  assign o_ALUOp    = r_ALUOp;
  assign o_RegDst   = r_RegDst;
  assign o_ALUSrc   = r_ALUSrc;
  assign o_MemRead  = r_MemRead;
  assign o_MemWrite = r_MemWrite;
  assign o_MemToReg = r_MemToReg;
  assign o_RegWrite = r_RegWrite;
  assign o_Halt     = r_Halt;
  assign o_Valid    = r_Valid;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: an abstract whole-bundle model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [1:0]  aluop;
    logic        regdst;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic        halt;
    logic        valid;
  } bundle_t;

  logic    clk = 1'b0;
  logic    reset, step, stall, flush;
  bundle_t din;
  bundle_t dout;

  logic [31:0] o_pc, o_rega, o_regb, o_imm;
  logic [4:0]  o_shamt, o_rs, o_rt, o_rd;
  logic [5:0]  o_funct, o_opcode;
  logic [1:0]  o_aluop;
  logic        o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_halt, o_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .i_clk(clk), .i_reset(reset), .i_step(step), .i_stall(stall), .i_flush(flush),
    .i_PC(din.pc), .i_RegA(din.rega), .i_RegB(din.regb), .i_Imm(din.imm),
    .i_Shamt(din.shamt), .i_Rs(din.rs), .i_Rt(din.rt), .i_Rd(din.rd),
    .i_Funct(din.funct), .i_Opcode(din.opcode), .i_ALUOp(din.aluop),
    .i_RegDst(din.regdst), .i_ALUSrc(din.alusrc), .i_MemRead(din.memread),
    .i_MemWrite(din.memwrite), .i_MemToReg(din.memtoreg), .i_RegWrite(din.regwrite),
    .i_Halt(din.halt), .i_Valid(din.valid),
    .o_PC(o_pc), .o_RegA(o_rega), .o_RegB(o_regb), .o_Imm(o_imm),
    .o_Shamt(o_shamt), .o_Rs(o_rs), .o_Rt(o_rt), .o_Rd(o_rd),
    .o_Funct(o_funct), .o_Opcode(o_opcode), .o_ALUOp(o_aluop),
    .o_RegDst(o_regdst), .o_ALUSrc(o_alusrc), .o_MemRead(o_memread),
    .o_MemWrite(o_memwrite), .o_MemToReg(o_memtoreg), .o_RegWrite(o_regwrite),
    .o_Halt(o_halt), .o_Valid(o_valid)
  );

  assign dout = {o_pc, o_rega, o_regb, o_imm, o_shamt, o_rs, o_rt, o_rd, o_funct,
                 o_opcode, o_aluop, o_regdst, o_alusrc, o_memread, o_memwrite,
                 o_memtoreg, o_regwrite, o_halt, o_valid};

  // Model: what EX must see is either nothing (zero), the previous instruction,
  // or the instruction presented by ID, chosen by the control inputs.
  bundle_t exp_b;
  logic    model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_b    = '0;
      model_ok = 1'b1;
    end else if (model_ok && step) begin
      if (flush)       exp_b = '0;
      else if (!stall) exp_b = din;
    end
    #1;
    if (model_ok) begin
      tests++;
      if (dout !== exp_b) begin
        fails++;
        $display("FAIL model_cycle t=%0t got=%h want=%h", $time, dout, exp_b);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic bundle_t rnd_bundle();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return bundle_t'(r[$bits(bundle_t)-1:0]);
  endfunction

  // Advance one clock edge; inputs change and literals are checked at negedge.
  task automatic edge1();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; step = 1'b1; stall = 1'b0; flush = 1'b0;
    din = rnd_bundle();
    din.valid = 1'b1; din.halt = 1'b1; din.aluop = 2'b11;
    edge1();
    // 1: reset with random inputs
    chk("reset_all_zero", 64'(dout == '0), 64'd1);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_aluop", 64'(o_aluop), 64'd0);

    // 2: load an R-type SUB
    reset = 1'b0;
    din = '0;
    din.funct = 6'b100010; din.aluop = 2'b10; din.rega = 32'h5; din.regb = 32'h3;
    din.regwrite = 1'b1; din.valid = 1'b1; din.rd = 5'd9; din.pc = 32'h0000_0104;
    edge1();
    chk("load_funct", 64'(o_funct), 64'h22);
    chk("load_aluop", 64'(o_aluop), 64'h2);
    chk("load_rega", 64'(o_rega), 64'h5);
    chk("load_regb", 64'(o_regb), 64'h3);
    chk("load_regwrite", 64'(o_regwrite), 64'd1);
    chk("load_valid", 64'(o_valid), 64'd1);
    chk("load_pc", 64'(o_pc), 64'h104);

    // 3: stall for 3 edges holds SUB, release loads AND
    stall = 1'b1; din.funct = 6'b100100;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("stall_hold_funct", 64'(o_funct), 64'h22);
    end
    stall = 1'b0;
    edge1();
    chk("stall_release_funct", 64'(o_funct), 64'h24);

    // 4: load SW, then flush it
    din = '0;
    din.opcode = 6'b101011; din.memwrite = 1'b1; din.aluop = 2'b00; din.alusrc = 1'b1;
    din.funct = 6'b000111; din.imm = 32'h10; din.valid = 1'b1;
    edge1();
    chk("sw_memwrite", 64'(o_memwrite), 64'd1);
    chk("sw_opcode", 64'(o_opcode), 64'h2b);
    flush = 1'b1;
    edge1();
    chk("flush_memwrite", 64'(o_memwrite), 64'd0);
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_aluop", 64'(o_aluop), 64'd0);
    chk("flush_funct", 64'(o_funct), 64'd0);
    chk("flush_imm", 64'(o_imm), 64'd0);

    // 5: flush+stall together with RegWrite: bubble, not hold
    din = '0; din.regwrite = 1'b1; din.valid = 1'b1; din.rd = 5'd4; din.funct = 6'b100000;
    flush = 1'b0;
    edge1();
    chk("pre_fs_regwrite", 64'(o_regwrite), 64'd1);
    flush = 1'b1; stall = 1'b1;
    edge1();
    chk("fs_regwrite", 64'(o_regwrite), 64'd0);
    chk("fs_valid", 64'(o_valid), 64'd0);
    chk("fs_rd", 64'(o_rd), 64'd0);

    // 6: step gating: load known instruction with Halt, then freeze
    flush = 1'b0; stall = 1'b0;
    din = '0; din.funct = 6'b000111; din.halt = 1'b1; din.valid = 1'b1; din.rs = 5'd17;
    edge1();
    chk("halt_propagates", 64'(o_halt), 64'd1);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = 1'(i); stall = 1'(i >> 1);
      din = rnd_bundle();
      edge1();
      chk("step_frozen_funct", 64'(o_funct), 64'h7);
      chk("step_frozen_rs", 64'(o_rs), 64'd17);
      chk("step_frozen_valid", 64'(o_valid), 64'd1);
    end
    step = 1'b1; flush = 1'b0; stall = 1'b0;
    din = '0; din.funct = 6'b101010; din.rt = 5'd31; din.valid = 1'b1;
    edge1();
    chk("step_release_funct", 64'(o_funct), 64'h2a);
    chk("step_release_rt", 64'(o_rt), 64'd31);

    // Reset while stalling wins; after deassert first edge loads
    stall = 1'b1; reset = 1'b1;
    edge1();
    chk("reset_in_stall", 64'(dout == '0), 64'd1);
    reset = 1'b0; stall = 1'b0;
    din.funct = 6'b100101;
    edge1();
    chk("post_reset_load", 64'(o_funct), 64'h25);

    // Random mix, checked by the per-cycle model only
    for (int i = 0; i < 200; i++) begin
      din   = rnd_bundle();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      step  = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 40) == 0);
      edge1();
    end
    reset = 1'b0;
    edge1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
